// File: rtl/ifd_scoreboard.sv
// ifd_scoreboard
//   Runs alongside the PDP-8 instruction fetch/decode unit. Each fetch is
//   tracked through a read pipe (RD_LATENCY) and a decode pipe
//   (DEC_LATENCY). The golden decode is formed when read data is valid and
//   compared against the IFD outputs when they become valid. Also checks
//   stall compliance, fetch-address sequencing and post-HLT silence.
//
// Ports
//   clk, reset_n          clock; reset is asynchronous and active-high
//   stall                 execution-unit stall
//   pc_load, pc_value     PC redirect from the execution unit
//   ifu_rd_req/addr/data  IFD fetch request, address and memory read data
//   dut_mem_op/off/op7    IFD decode outputs under check
//   err_clr               synchronous clear of flags, counters and done
//   err_decode/stall/addr/done  sticky error flags
//   done                  an HLT was fetched and compared
//   err_count, chk_count  saturating error-cycle and compare counters
module ifd_scoreboard #(
  parameter int                    ADDR_WIDTH    = 12,
  parameter int                    DATA_WIDTH    = 12,
  parameter int                    RD_LATENCY    = 1,
  parameter int                    DEC_LATENCY   = 2,
  parameter logic [ADDR_WIDTH-1:0] START_ADDRESS = 12'o200,
  parameter int                    CNT_WIDTH     = 16,
  parameter bit                    CHK_SEQ       = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_value,
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  input  logic [DATA_WIDTH-1:0] ifu_rd_data,
  input  logic [5:0]            dut_mem_op,
  input  logic [8:0]            dut_mem_off,
  input  logic [21:0]           dut_op7,
  input  logic                  err_clr,
  output logic                  err_decode,
  output logic                  err_stall,
  output logic                  err_addr,
  output logic                  err_done,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [CNT_WIDTH-1:0]  chk_count
);

  // Group-7 one-hot bit positions (pdp8_pkg order, NOP..CLA2)
  localparam int B_NOP  = 0,  B_IAC = 1,  B_RAL = 2,  B_RTL = 3,  B_RAR = 4;
  localparam int B_RTR  = 5,  B_CML = 6,  B_CMA = 7,  B_CIA = 8,  B_CLL = 9;
  localparam int B_STL  = 10, B_CLA1 = 11, B_HLT = 12, B_OSR = 13, B_SKP = 14;
  localparam int B_SNL  = 15, B_SZL = 16, B_SZA = 17, B_SNA = 18, B_SMA = 19;
  localparam int B_SPA  = 20, B_CLA2 = 21;

  localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;
  localparam logic [CNT_WIDTH-1:0]  C_ONE = 1;
  localparam logic [CNT_WIDTH-1:0]  C_MAX = '1;

  typedef struct packed {
    logic        vld;
    logic [5:0]  mem_op;
    logic [8:0]  off;
    logic [21:0] op7;
  } dec_t;

  // Exact match on the low 9 bits of a 7xxx word; unlisted codes are NOP.
  function automatic logic [21:0] op7_decode(input logic [8:0] c);
    logic [21:0] r;
    r = '0;
    case (c)
      9'o000:  r[B_NOP]  = 1'b1;
      9'o001:  r[B_IAC]  = 1'b1;
      9'o004:  r[B_RAL]  = 1'b1;
      9'o006:  r[B_RTL]  = 1'b1;
      9'o010:  r[B_RAR]  = 1'b1;
      9'o012:  r[B_RTR]  = 1'b1;
      9'o020:  r[B_CML]  = 1'b1;
      9'o040:  r[B_CMA]  = 1'b1;
      9'o041:  r[B_CIA]  = 1'b1;
      9'o100:  r[B_CLL]  = 1'b1;
      9'o120:  r[B_STL]  = 1'b1;
      9'o200:  r[B_CLA1] = 1'b1;
      9'o402:  r[B_HLT]  = 1'b1;
      9'o404:  r[B_OSR]  = 1'b1;
      9'o410:  r[B_SKP]  = 1'b1;
      9'o420:  r[B_SNL]  = 1'b1;
      9'o430:  r[B_SZL]  = 1'b1;
      9'o440:  r[B_SZA]  = 1'b1;
      9'o450:  r[B_SNA]  = 1'b1;
      9'o500:  r[B_SMA]  = 1'b1;
      9'o510:  r[B_SPA]  = 1'b1;
      9'o600:  r[B_CLA2] = 1'b1;
      default: r[B_NOP]  = 1'b1;
    endcase
    return r;
  endfunction

  logic [RD_LATENCY:1]   rd_vld_q;
  dec_t                  dec_q [DEC_LATENCY:1];
  logic                  stall_q;
  logic                  first_fetch_q;
  logic [ADDR_WIDTH-1:0] expect_addr_q;
  logic                  err_decode_q, err_stall_q, err_addr_q, err_done_q, done_q;
  logic [CNT_WIDTH-1:0]  err_count_q, chk_count_q;

  // Golden decode, formed in the data-valid cycle
  logic [2:0]  opcode;
  logic [5:0]  g_mem_op;
  logic [8:0]  g_off;
  logic [21:0] g_op7;

  always_comb begin
    opcode   = ifu_rd_data[DATA_WIDTH-1 -: 3];
    g_mem_op = '0;
    g_off    = '0;
    g_op7    = '0;
    if (opcode <= 3'd5) begin
      g_mem_op = 6'b000001 << opcode;
      g_off    = ifu_rd_data[8:0];
    end else if (opcode == 3'd7) begin
      g_op7 = op7_decode(ifu_rd_data[8:0]);
    end
  end

  dec_t                  cmp;
  logic                  dec_bad, stall_bad, done_bad, addr_bad, any_bad;
  logic [ADDR_WIDTH-1:0] addr_exp;

  assign cmp = dec_q[DEC_LATENCY];

  // 4-state compares so X/Z on the IFD outputs counts as a mismatch;
  // mem_off only matters for memory-reference instructions.
  assign dec_bad   = cmp.vld && ((dut_mem_op !== cmp.mem_op) ||
                                 (dut_op7 !== cmp.op7) ||
                                 ((cmp.mem_op != 6'd0) && (dut_mem_off !== cmp.off)));
  assign stall_bad = ifu_rd_req && stall_q;
  assign done_bad  = ifu_rd_req && done_q;
  // first fetch after reset is pinned to START_ADDRESS even if a redirect
  // arrived before it
  assign addr_exp  = first_fetch_q ? START_ADDRESS : expect_addr_q;
  assign addr_bad  = CHK_SEQ && ifu_rd_req && (ifu_rd_addr != addr_exp);
  assign any_bad   = dec_bad || stall_bad || done_bad || addr_bad;

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      rd_vld_q      <= '0;
      for (int i = 1; i <= DEC_LATENCY; i++) dec_q[i] <= '0;
      stall_q       <= 1'b0;
      first_fetch_q <= 1'b1;
      expect_addr_q <= START_ADDRESS;
      err_decode_q  <= 1'b0;
      err_stall_q   <= 1'b0;
      err_addr_q    <= 1'b0;
      err_done_q    <= 1'b0;
      done_q        <= 1'b0;
      err_count_q   <= '0;
      chk_count_q   <= '0;
    end else begin
      rd_vld_q[1] <= ifu_rd_req;
      for (int i = 2; i <= RD_LATENCY; i++) rd_vld_q[i] <= rd_vld_q[i-1];
      dec_q[1] <= {rd_vld_q[RD_LATENCY], g_mem_op, g_off, g_op7};
      for (int i = 2; i <= DEC_LATENCY; i++) dec_q[i] <= dec_q[i-1];

      stall_q <= stall;
      if (ifu_rd_req) first_fetch_q <= 1'b0;
      // redirect beats the sequential increment
      if (pc_load)         expect_addr_q <= pc_value;
      else if (ifu_rd_req) expect_addr_q <= ifu_rd_addr + A_ONE;

      if (err_clr) begin
        err_decode_q <= 1'b0;
        err_stall_q  <= 1'b0;
        err_addr_q   <= 1'b0;
        err_done_q   <= 1'b0;
        done_q       <= 1'b0;
        err_count_q  <= '0;
        chk_count_q  <= '0;
      end else begin
        if (dec_bad)   err_decode_q <= 1'b1;
        if (stall_bad) err_stall_q  <= 1'b1;
        if (addr_bad)  err_addr_q   <= 1'b1;
        if (done_bad)  err_done_q   <= 1'b1;
        if (cmp.vld && cmp.op7[B_HLT]) done_q <= 1'b1;
        if (any_bad && (err_count_q != C_MAX)) err_count_q <= err_count_q + C_ONE;
        if (cmp.vld && (chk_count_q != C_MAX)) chk_count_q <= chk_count_q + C_ONE;
      end
    end
  end

  assign err_decode = err_decode_q;
  assign err_stall  = err_stall_q;
  assign err_addr   = err_addr_q;
  assign err_done   = err_done_q;
  assign done       = done_q;
  assign err_count  = err_count_q;
  assign chk_count  = chk_count_q;

endmodule

// File: tb/tb_ifd_scoreboard.sv
// Directed bench for ifd_scoreboard at default parameters (RD=1, DEC=2).
// The bench plays the memory and the IFD: each fetch schedules its read
// data one cycle later and hand-written IFD decode values three cycles later.
module tb_ifd_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        stall = 1'b0, pc_load = 1'b0, ifu_rd_req = 1'b0, err_clr = 1'b0;
  logic [11:0] pc_value = '0, ifu_rd_addr = '0, ifu_rd_data = '0;
  logic [5:0]  dut_mem_op = '0;
  logic [8:0]  dut_mem_off = '0;
  logic [21:0] dut_op7 = '0;
  logic        err_decode, err_stall, err_addr, err_done, done;
  logic [15:0] err_count, chk_count;

  int nvec = 0, nerr = 0, c = 0;
  logic [11:0] dtab [64];
  logic [5:0]  mtab [64];
  logic [8:0]  otab [64];
  logic [21:0] ptab [64];

  localparam logic [21:0] OP7_NOP = 22'h000001;
  localparam logic [21:0] OP7_IAC = 22'h000002;
  localparam logic [21:0] OP7_HLT = 22'h001000;

  ifd_scoreboard dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .pc_load(pc_load),
    .pc_value(pc_value), .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr),
    .ifu_rd_data(ifu_rd_data), .dut_mem_op(dut_mem_op), .dut_mem_off(dut_mem_off),
    .dut_op7(dut_op7), .err_clr(err_clr), .err_decode(err_decode),
    .err_stall(err_stall), .err_addr(err_addr), .err_done(err_done),
    .done(done), .err_count(err_count), .chk_count(chk_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_tabs();
    for (int i = 0; i < 64; i++) begin
      dtab[i] = '0; mtab[i] = '0; otab[i] = '0; ptab[i] = '0;
    end
  endtask

  // One clock cycle. stall/pc_load/pc_value/err_clr are set by the caller
  // beforehand and dropped again after the edge.
  task automatic cyc(input bit req, input logic [11:0] addr = 12'o0,
                     input logic [11:0] data = 12'o1234, input bit bad = 1'b0);
    int s, sd, sp;
    logic [5:0]  m;
    logic [8:0]  o;
    logic [21:0] p;
    s = c % 64; sd = (c + 1) % 64; sp = (c + 3) % 64;
    ifu_rd_req  = req;
    ifu_rd_addr = addr;
    ifu_rd_data = dtab[s];
    dut_mem_op  = mtab[s];
    dut_mem_off = otab[s];
    dut_op7     = ptab[s];
    if (req) begin
      m = '0; o = '0; p = '0;
      case (data)
        12'o1234: begin m = 6'b000010; o = 9'o234; end
        12'o5377: begin m = 6'b100000; o = 9'o377; end
        12'o7402: p = OP7_HLT;
        12'o7000: p = bad ? OP7_IAC : OP7_NOP;
        default: ;
      endcase
      dtab[sd] = data; mtab[sp] = m; otab[sp] = o; ptab[sp] = p;
    end
    @(posedge clk); #1;
    dtab[s] = '0; mtab[s] = '0; otab[s] = '0; ptab[s] = '0;
    c++;
    ifu_rd_req = 1'b0; stall = 1'b0; pc_load = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    clr_tabs();
    c = 0;
    reset_n = 1'b1;
    ifu_rd_req = 1'b0; stall = 1'b0; pc_load = 1'b0; err_clr = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_err_decode", err_decode, 0);
    chk("rst_done", done, 0);
    chk("rst_chk_count", chk_count, 0);
    chk("rst_err_count", err_count, 0);

    // back-to-back correct fetches: TAD, JMP, HLT
    cyc(1, 12'o200, 12'o1234);
    cyc(1, 12'o201, 12'o5377);
    cyc(1, 12'o202, 12'o7402);
    cyc(0);
    chk("t1_chk_after_first", chk_count, 1);
    cyc(0);
    chk("t1_done_before_hlt", done, 0);
    cyc(0);
    chk("t1_chk_count", chk_count, 3);
    chk("t1_done", done, 1);
    chk("t1_flags", {err_decode, err_stall, err_addr, err_done}, 0);
    chk("t1_err_count", err_count, 0);

    // wrong group-7 decode: IAC reported for 7000
    do_reset();
    cyc(1, 12'o200, 12'o7000, 1'b1);
    cyc(0); cyc(0);
    chk("t2_decode_early", err_decode, 0);
    cyc(0);
    chk("t2_err_decode", err_decode, 1);
    chk("t2_err_count", err_count, 1);

    // fetch right after a stall cycle
    do_reset();
    cyc(1, 12'o200);
    stall = 1'b1; cyc(0);
    cyc(1, 12'o201);
    chk("t3_err_stall", err_stall, 1);
    chk("t3_err_count", err_count, 1);
    chk("t3_err_addr", err_addr, 0);
    do_reset();
    cyc(1, 12'o200);
    cyc(0);
    cyc(1, 12'o201);
    chk("t3_no_stall", err_stall, 0);

    // wrong first address
    do_reset();
    cyc(1, 12'o201);
    chk("t4_first_addr", err_addr, 1);
    // redirects, wrap, and first fetch pinned to START despite pc_load
    do_reset();
    pc_load = 1'b1; pc_value = 12'o400; cyc(1, 12'o200);
    cyc(1, 12'o400);
    pc_load = 1'b1; pc_value = 12'o350; cyc(0);
    cyc(1, 12'o350);
    pc_load = 1'b1; pc_value = 12'o7777; cyc(0);
    cyc(1, 12'o7777);
    cyc(1, 12'o0000);
    chk("t4_redirect_wrap", err_addr, 0);
    cyc(1, 12'o0002);
    chk("t4_skip_addr", err_addr, 1);
    chk("t4_err_count", err_count, 1);

    // fetch after HLT, then clear
    do_reset();
    cyc(1, 12'o200, 12'o7402);
    cyc(0); cyc(0); cyc(0);
    chk("t5_done", done, 1);
    cyc(1, 12'o201);
    chk("t5_err_done", err_done, 1);
    chk("t5_err_addr", err_addr, 0);
    cyc(0); cyc(0); cyc(0);
    err_clr = 1'b1; cyc(0);
    chk("t5_clr_flags", {err_decode, err_stall, err_addr, err_done, done}, 0);
    chk("t5_clr_err_count", err_count, 0);
    chk("t5_clr_chk_count", chk_count, 0);
    // clear wins over a same-cycle error
    stall = 1'b1; cyc(0);
    err_clr = 1'b1; cyc(1, 12'o202);
    chk("t5_clr_wins_flag", err_stall, 0);
    chk("t5_clr_wins_count", err_count, 0);

    // reset with fetches in flight drops their compares
    do_reset();
    cyc(1, 12'o200);
    cyc(1, 12'o201);
    reset_n = 1'b1; #2; reset_n = 1'b0;
    clr_tabs();
    cyc(0); cyc(0); cyc(0); cyc(0);
    chk("t6_inflight_chk", chk_count, 0);
    chk("t6_inflight_flags", {err_decode, done}, 0);
    cyc(1, 12'o200);
    chk("t6_start_restored", err_addr, 0);

    // saturation: error every cycle for more than 2^16 cycles
    do_reset();
    stall = 1'b1; ifu_rd_req = 1'b1; ifu_rd_addr = 12'o200;
    ifu_rd_data = '0; dut_mem_op = '0; dut_mem_off = '0; dut_op7 = '0;
    repeat (65541) @(posedge clk);
    #1;
    chk("t7_err_count_sat", err_count, 16'hFFFF);
    chk("t7_chk_count_sat", chk_count, 16'hFFFF);
    @(posedge clk); #1;
    chk("t7_err_count_hold", err_count, 16'hFFFF);
    stall = 1'b0; ifu_rd_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ifd_scoreboard.md
Name: ifd_scoreboard

Overview:
Synthesizable, parametrised scoreboard for the PDP-8 instruction fetch/decode unit (IFD). It runs in parallel with the IFD. For every fetch it computes the golden decode, pipelined for configurable memory and decode latencies with multiple fetches in flight, and compares it against the IFD decode outputs. It also checks stall compliance, fetch-address sequencing (including PC redirects from the execution unit) and post-HLT silence, and reports sticky error flags and saturating counters to the testbench or the status register file.

Parameters:
ADDR_WIDTH, 12, fetch address width.
DATA_WIDTH, 12, instruction width; opcode is data[DATA_WIDTH-1:DATA_WIDTH-3].
RD_LATENCY, 1, cycles from the ifu_rd_req cycle to the cycle ifu_rd_data is valid; range 1..4.
DEC_LATENCY, 2, cycles from the data-valid cycle to the cycle the IFD decode outputs are valid; range 1..4.
START_ADDRESS, 12'o200, required address of the first fetch after reset.
CNT_WIDTH, 16, width of the error and compare counters.
CHK_SEQ, 1, 1 = enable the address-sequencing check.

Ports:
clk  in  1  clock.
reset_n  in  1  reset; asynchronous, active-high.
stall  in  1  execution-unit stall.
pc_load  in  1  execution unit redirects the PC this cycle.
pc_value  in  ADDR_WIDTH  redirect target, valid when pc_load=1.
ifu_rd_req  in  1  IFD fetch request.
ifu_rd_addr  in  ADDR_WIDTH  fetch address.
ifu_rd_data  in  DATA_WIDTH  memory read data.
dut_mem_op  in  6  IFD one-hot memory opcode, bit0=AND .. bit5=JMP.
dut_mem_off  in  9  IFD page/offset field.
dut_op7  in  22  IFD one-hot group-7 opcode, bit0=NOP .. bit21=CLA2, in pdp8_pkg order.
err_clr  in  1  synchronous clear of flags and counters.
err_decode  out  1  sticky: decode mismatch.
err_stall  out  1  sticky: fetch issued after a stall cycle.
err_addr  out  1  sticky: wrong fetch address.
err_done  out  1  sticky: fetch issued after HLT.
done  out  1  an HLT was fetched and compared.
err_count  out  CNT_WIDTH  saturating count of cycles with at least one new error.
chk_count  out  CNT_WIDTH  saturating count of decode compares performed.

Behaviour:
- Reset (reset_n=1, asynchronous): all outputs 0; pipeline valid bits cleared; expect_addr=START_ADDRESS; first_fetch=1. In-flight compares are dropped and never reported.
- Request pipe: a shift register of depth RD_LATENCY carries {valid, addr} per cycle, so back-to-back requests are allowed. When stage RD_LATENCY is valid, ifu_rd_data is sampled and the golden decode is formed in that same cycle.
- Golden decode:
  - opcode 0..5: mem_op one-hot (bit=opcode), mem_off=data[8:0], op7=0.
  - opcode 6 (IOT): mem_op=0, op7=0.
  - opcode 7: op7 = one-hot of the exact pdp8_pkg encoding (NOP..CLA2); any unlisted code gives the NOP bit; mem_op=0.
- Decode pipe: depth DEC_LATENCY carries {valid, exp_mem_op, exp_off, exp_op7}.
  - At stage DEC_LATENCY: chk_count+1.
  - Mismatch sets err_decode if dut_mem_op!=exp_mem_op, or dut_op7!=exp_op7, or (exp_mem_op!=0 and dut_mem_off!=exp_off). mem_off is don't-care otherwise.
  - Comparisons are 4-state (===): X or Z on any DUT output is a mismatch.
- HLT compared with exp_op7 HLT bit set: done=1, held until reset or err_clr.
- Stall check: ifu_rd_req=1 in cycle N with stall=1 in cycle N-1 sets err_stall.
- Done check: ifu_rd_req=1 while done=1 sets err_done.
- Address check (CHK_SEQ=1), on each ifu_rd_req:
  - The request sets err_addr if ifu_rd_addr!=expect_addr.
  - Then expect_addr=ifu_rd_addr+1, modulo 2^ADDR_WIDTH, so 12'o7777 wraps to 0.
  - pc_load=1 sets expect_addr=pc_value; this takes priority over the +1 update in the same cycle.
  - The first fetch after reset must equal START_ADDRESS regardless of pc_load.
- err_count: +1 per cycle in which any sticky flag's set condition is true, even if the flag is already set. Multiple errors in one cycle count once. Saturates at all-ones; same for chk_count.
- err_clr (synchronous): clears all flags, both counters and done. Pipelines and expect_addr are not cleared. If err_clr and an error set occur in the same cycle, err_clr wins.

Test Plan:
- Reset, then fetches at 0200,0201,0202 returning 1234,5377,7402 (RD=1, DEC=2) with a correct DUT -> chk_count=3, done=1, all err flags 0.
- DUT drives dut_op7 bit1 (IAC) for fetched 7000 -> err_decode=1, err_count=1 in the DEC_LATENCY compare cycle.
- stall=1 in cycle 10, ifu_rd_req=1 in cycle 11 -> err_stall=1; same sequence with stall low -> no error.
- First fetch at 0201 -> err_addr=1. pc_load with pc_value=0350, next fetch 0350 -> no error. Fetch 7777 then 0000 -> no error.
- Fetch 7402 then another request after done -> err_done=1. Then err_clr -> all flags, counters and done return to 0.
- Assert reset with 2 fetches in flight -> no compare, chk_count=0. Holding errors for 2^CNT_WIDTH+5 cycles -> err_count holds all-ones.
